input_sched: RTL and testbench
==============================

# input_sched

Round-robin scheduler that shares the 4-bit sample-conversion datapath (offset +8, round, range check → 6-bit unsigned code) among NUM_CH requesting sample channels. It sits between the per-channel front-end sample sources and the downstream SDR pipeline. It grants one channel at a time for a burst of up to BURST_LEN samples and converts each accepted sample. Results go out through a single registered valid/ready port tagged with the source channel.

## Interface
- NUM_CH, 4, number of requesting channels (2..8)
- BURST_LEN, 4, max samples accepted per grant before rotation (1..15)
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  scheduler enable; low stops new grants
- req_valid  input  NUM_CH  per-channel sample valid
- req_data  input  4*NUM_CH  per-channel signed 4-bit sample, channel i at [4i+3:4i]
- req_ready  output  NUM_CH  per-channel accept; at most one bit high
- out_valid  output  1  converted sample valid
- out_ready  input  1  downstream accept
- out_data  output  6  converted unsigned code (0..7 used)
- out_ch  output  $clog2(NUM_CH)  source channel of out_data
- out_oor  output  1  sample was out of range (outside -6..5)
- busy  output  1  state != IDLE or out_valid

## Operation
- FSM states: IDLE, GRANT, DRAIN.
- IDLE:
  - if en and any req_valid, select the first valid channel strictly after last_ch (cyclic).
  - Load grant_ch, clear burst_cnt, go to GRANT.
- GRANT:
  - req_ready[grant_ch] = !out_valid || out_ready; all other req_ready bits are 0.
  - Beat = req_valid[grant_ch] && req_ready[grant_ch]. Each beat increments burst_cnt.
  - Release to IDLE and set last_ch = grant_ch when either:
    - a beat occurs with burst_cnt == BURST_LEN-1, or
    - req_valid[grant_ch] is low in a cycle where req_ready is high (source gap).
  - en low → DRAIN; the beat of that same cycle is still accepted, and last_ch = grant_ch.
- DRAIN:
  - No req_ready.
  - Go to IDLE once out_valid is 0, or once out_valid && out_ready.
- Conversion of sample s:
  - in range when -6 <= s <= 5; code = (s + 9) >> 1, computed at ≥6 bits signed.
  - Mapping: -6→1, -5/-4→2, -3/-2→3, -1/0→4, 1/2→5, 3/4→6, 5→7.
  - out of range (s in -8..-7, 6..7): code = 0, out_oor = 1.
- Output register:
  - On a beat, load out_data, out_ch = grant_ch, out_oor, and set out_valid.
  - Otherwise out_valid clears on out_ready.
  - Payload is stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE; last_ch = NUM_CH-1 (channel 0 wins first); burst_cnt 0; req_ready 0; out_valid 0, out_data 0, out_ch 0, out_oor 0; busy 0.
- rst mid-burst: in-flight output is discarded, no further req_ready, and arbitration restarts from channel 0.
- Arbitration costs 1 cycle. Valid seen in IDLE at cycle N → GRANT at N+1 → first req_ready at N+1.
- Beat at edge N → out_valid visible in cycle N+1 (latency 1).
- Sustained throughput is 1 sample/cycle within a burst; the inter-burst gap is 1 IDLE cycle.
- Backpressure: out_ready low with out_valid high → req_ready low; no sample is lost or duplicated.
- Simultaneous beat and downstream pop: out register reloads, out_valid stays 1.
- Granted channel is held even if higher-priority channels become valid mid-burst.
- BURST_LEN = 1: every beat releases the grant.

## Configuration
- INPUT_SCHED_CLAMP_EN defined: out-of-range samples clamp instead of zeroing.
  - s <= -7 → code 1
  - s >= 6 → code 7
  - out_oor is still asserted.
- INPUT_SCHED_CLAMP_EN undefined: out-of-range code = 0.

## Structure
- Package input_sched_pkg holds:
  - state enum (IDLE, GRANT, DRAIN)
  - sample width constant (4) and code width constant (6)
  - range bounds (-6, 5) and offset constants (+8 offset, +1 rounding)
  - function conv_sample returning {oor, code}
- One sub-module, rr_pick: combinational next-valid-after-pointer search, parameterised by NUM_CH.

## Test plan
- Reset, then ch0 valid with s = -6, 0, 5, 7 and out_ready = 1 → out_data 1, 4, 7, 0 on consecutive cycles, out_ch 0, out_oor only on the last; first req_ready 1 cycle after valid.
- All 4 channels continuously valid, BURST_LEN = 4 → bursts of 4 in order ch0, ch1, ch2, ch3, ch0, with 1 idle cycle between bursts.
- out_ready held low 5 cycles mid-burst → req_ready low throughout, out_data stable, the following 3 samples appear in order with no loss.
- ch1 drops valid after 2 beats while ch2 is valid → ch1 released, ch2 granted 2 cycles later; burst_cnt restarts at 0.
- en dropped during GRANT with out_valid = 1 and out_ready = 0 → DRAIN until the pop, then IDLE; busy falls the cycle after.
- rst asserted mid-burst on ch2 → next cycle all outputs are at reset values; after release, ch0 is granted first; with INPUT_SCHED_CLAMP_EN, s = 7 yields code 7 with out_oor = 1.

Source files
------------

// File: rtl/input_sched_pkg.sv
// input_sched_pkg: shared types, constants and the sample conversion for input_sched.
// INPUT_SCHED_CLAMP_EN makes out-of-range samples clamp to the nearest in-range code instead of zero.
package input_sched_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
    localparam int SAMPLE_W = 4;
    localparam int CODE_W = 6;
    localparam int SAMPLE_MIN = -6;
    localparam int SAMPLE_MAX = 5;
    localparam int OFFSET = 8;
    localparam int ROUND = 1;
    function automatic logic [CODE_W:0] conv_sample(input logic [SAMPLE_W-1:0] s);
        int v;
        logic oor;
        logic [CODE_W-1:0] code;
        v = int'($signed(s));
        oor = v < SAMPLE_MIN || v > SAMPLE_MAX;
`ifdef INPUT_SCHED_CLAMP_EN
        v = !oor ? v : v < 0 ? SAMPLE_MIN : SAMPLE_MAX;
        code = CODE_W'((v + OFFSET + ROUND) >>> 1);
`else
        code = oor ? '0 : CODE_W'((v + OFFSET + ROUND) >>> 1);
`endif
        return {oor, code};
    endfunction
endpackage

// File: rtl/input_sched_if.sv
// input_sched_if: per-channel request bus plus the tagged converted-sample output port.
interface input_sched_if
    import input_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH-1:0] req_valid;
    logic [NUM_CH-1:0] req_ready;
    logic [SAMPLE_W*NUM_CH-1:0] req_data;
    logic out_valid;
    logic out_ready;
    logic out_oor;
    logic [CODE_W-1:0] out_data;
    logic [$clog2(NUM_CH)-1:0] out_ch;
    modport master(
        output req_valid, req_data, out_ready,
        input req_ready, out_valid, out_data, out_ch, out_oor
    );
    modport slave(
        input req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_ch, out_oor
    );
endinterface

// File: rtl/input_sched_rr_pick.sv
// rr_pick: finds the first valid channel strictly after ptr, wrapping cyclically.
module rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         valid,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic                      any,
    output logic [$clog2(NUM_CH)-1:0] idx
);
    localparam int W = $clog2(NUM_CH);
    logic [W-1:0] c;
    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        c = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = W'((int'(ptr) + i) % NUM_CH);
            if (valid[c]) begin
                any = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/input_sched.sv
// input_sched: round-robin burst scheduler feeding one shared sample converter and a registered output.
// INPUT_SCHED_CLAMP_EN (in input_sched_pkg) selects clamping of out-of-range samples.
module input_sched
    import input_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int BURST_LEN = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          en,
    input_sched_if.slave bus,
    output logic         busy
);
    localparam int W = $clog2(NUM_CH);
    state_t state, state_nx;
    logic [W-1:0] grant_ch, last_ch, pick_idx;
    logic [3:0] burst_cnt;
    logic pick_any, can_acc, gv, beat, release_g;
    logic [NUM_CH-1:0] rdy;
    logic [SAMPLE_W-1:0] sample;
    logic [CODE_W:0] conv;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .valid(bus.req_valid),
        .ptr  (last_ch),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        can_acc = !bus.out_valid || bus.out_ready;
        gv = bus.req_valid[grant_ch];
        sample = bus.req_data[SAMPLE_W*grant_ch +: SAMPLE_W];
        conv = conv_sample(sample);
        beat = state == GRANT && gv && can_acc;
        // A granted source that is offered a slot but has nothing gives up its turn.
        release_g = (beat && burst_cnt == 4'(BURST_LEN - 1)) || (can_acc && !gv);
        rdy = '0;
        rdy[grant_ch] = state == GRANT && can_acc;
        state_nx = state;
        case (state)
            IDLE:    state_nx = en && pick_any ? GRANT : IDLE;
            GRANT:   state_nx = !en ? DRAIN : release_g ? IDLE : GRANT;
            DRAIN:   state_nx = can_acc ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready = rdy;
    assign busy = state != IDLE || bus.out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant_ch <= '0;
            last_ch <= W'(NUM_CH - 1);
            burst_cnt <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch <= '0;
            bus.out_oor <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == GRANT) begin
                grant_ch <= pick_idx;
                burst_cnt <= '0;
            end
            if (state == GRANT && state_nx != GRANT) last_ch <= grant_ch;
            if (beat) begin
                burst_cnt <= burst_cnt + 4'd1;
                bus.out_valid <= 1'b1;
                bus.out_data <= conv[CODE_W-1:0];
                bus.out_ch <= grant_ch;
                bus.out_oor <= conv[CODE_W];
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_input_sched.sv
// tb_input_sched: table, directed-sequence and randomized scoreboard checks of input_sched.
module tb_input_sched;
    localparam int NUM_CH = 4;
    localparam int BURST_LEN = 4;

    typedef struct {int s; int code; bit oor;} vec_t;
    typedef struct {int ch; int code; bit oor;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic busy;
    int checks = 0;
    int errors = 0;

    input_sched_if #(.NUM_CH(NUM_CH)) bus ();

    input_sched #(.NUM_CH(NUM_CH), .BURST_LEN(BURST_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_oor(input int s);
        return s < -6 || s > 5;
    endfunction

    function automatic int model_code(input int s);
        if (!model_oor(s)) return (s + 9) / 2;
`ifdef INPUT_SCHED_CLAMP_EN
        return s < 0 ? 1 : 7;
`else
        return 0;
`endif
    endfunction

    function automatic logic [15:0] pack(input int ch, input int s);
        logic [15:0] d;
        d = '0;
        d[4*ch +: 4] = 4'(s);
        return d;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        en = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string p);
        chk({p, " out_valid"}, int'(bus.out_valid), 0);
        chk({p, " out_data"}, int'(bus.out_data), 0);
        chk({p, " out_ch"}, int'(bus.out_ch), 0);
        chk({p, " out_oor"}, int'(bus.out_oor), 0);
        chk({p, " busy"}, int'(busy), 0);
        chk({p, " req_ready"}, int'(bus.req_ready), 0);
    endtask

    task automatic wait_ready(input int ch, input string name);
        int n;
        n = 0;
        while (!bus.req_ready[ch] && n < 8) begin
            tick();
            n++;
        end
        chk(name, int'(bus.req_ready[ch]), 1);
    endtask

    initial begin
        vec_t tbl[16];
        int codes[16];
        int s1[4];
        int bp_s[3];
        logic [3:0] src[NUM_CH][$];
        exp_t expq[$];
        exp_t e;
        logic [3:0] v;
        logic [15:0] d;
        int acc;
        int left;
        bit drain;
        bit prev_hold;
        logic [9:0] prev_pay;

`ifdef INPUT_SCHED_CLAMP_EN
        codes = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 7};
`else
        codes = '{0, 0, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 0, 0};
`endif
        for (int i = 0; i < 16; i++) begin
            tbl[i].s = i - 8;
            tbl[i].code = codes[i];
            tbl[i].oor = i < 2 || i > 13;
        end

        reset_dut();
        check_reset("reset");

        // Conversion table through channel 0
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.req_valid = 4'b0001;
            bus.req_data = pack(0, tbl[i].s);
            #1;
            wait_ready(0, "tbl ready");
            tick();
            bus.req_valid = '0;
            #1;
            chk("tbl out_valid", int'(bus.out_valid), 1);
            chk($sformatf("tbl code s=%0d", tbl[i].s), int'(bus.out_data), tbl[i].code);
            chk($sformatf("tbl oor s=%0d", tbl[i].s), int'(bus.out_oor), int'(tbl[i].oor));
            chk("tbl out_ch", int'(bus.out_ch), 0);
        end

        // Back-to-back burst on ch0 with grant latency
        reset_dut();
        en = 1'b1;
        s1 = '{-6, 0, 5, 7};
        bus.req_valid = 4'b0001;
        bus.req_data = pack(0, s1[0]);
        #1;
        chk("s1 idle ready", int'(bus.req_ready), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.req_data = pack(0, s1[k]);
            #1;
            chk("s1 ready", int'(bus.req_ready), 1);
            tick();
            chk("s1 out_valid", int'(bus.out_valid), 1);
            chk($sformatf("s1 code %0d", k), int'(bus.out_data), model_code(s1[k]));
            chk($sformatf("s1 oor %0d", k), int'(bus.out_oor), int'(model_oor(s1[k])));
            chk("s1 out_ch", int'(bus.out_ch), 0);
        end
        bus.req_valid = '0;
        #1;
        chk("s1 released", int'(bus.req_ready), 0);

        // All channels valid: rotation with one idle cycle between bursts
        reset_dut();
        en = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data = 16'($urandom);
        #1;
        chk("rr idle", int'(bus.req_ready), 0);
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < BURST_LEN; j++) begin
                tick();
                bus.req_data = 16'($urandom);
                #1;
                chk($sformatf("rr burst %0d grant", b), int'(bus.req_ready), 1 << (b % 4));
            end
            tick();
            chk($sformatf("rr gap %0d", b), int'(bus.req_ready), 0);
            chk($sformatf("rr gap %0d out_ch", b), int'(bus.out_ch), b % 4);
            chk("rr gap busy", int'(busy), 1);
        end

        // Backpressure mid-burst
        reset_dut();
        en = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data = pack(0, -6);
        #1;
        tick();
        chk("bp grant", int'(bus.req_ready), 1);
        tick();
        bus.out_ready = 1'b0;
        bus.req_data = pack(0, -4);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp ready low", int'(bus.req_ready), 0);
            chk("bp data stable", int'(bus.out_data), 1);
            chk("bp valid held", int'(bus.out_valid), 1);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp ready back", int'(bus.req_ready), 1);
        bp_s = '{-4, -2, 0};
        for (int k = 0; k < 3; k++) begin
            bus.req_data = pack(0, bp_s[k]);
            #1;
            tick();
            chk($sformatf("bp sample %0d", k), int'(bus.out_data), model_code(bp_s[k]));
            chk("bp out_valid", int'(bus.out_valid), 1);
        end
        bus.req_valid = '0;

        // Source gap on ch1, then ch2 gets a fresh full burst
        reset_dut();
        en = 1'b1;
        bus.req_valid = 4'b0110;
        bus.req_data = 16'($urandom);
        #1;
        tick();
        chk("gap grant ch1", int'(bus.req_ready), 2);
        tick();
        chk("gap ch1 beat2", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        chk("gap offered", int'(bus.req_ready), 2);
        tick();
        chk("gap idle", int'(bus.req_ready), 0);
        bus.req_valid = 4'b0101;
        #1;
        tick();
        for (int j = 0; j < BURST_LEN; j++) begin
            chk($sformatf("gap ch2 hold %0d", j), int'(bus.req_ready), 4);
            tick();
        end
        chk("gap ch2 released", int'(bus.req_ready), 0);
        tick();
        chk("gap next ch0", int'(bus.req_ready), 1);

        // en dropped while the output is stalled
        reset_dut();
        en = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        en = 1'b0;
        #1;
        chk("en stall ready", int'(bus.req_ready), 0);
        tick();
        chk("drain busy", int'(busy), 1);
        chk("drain ready", int'(bus.req_ready), 0);
        chk("drain out_valid", int'(bus.out_valid), 1);
        tick();
        chk("drain busy2", int'(busy), 1);
        bus.out_ready = 1'b1;
        #1;
        chk("drain pop ready", int'(bus.req_ready), 0);
        tick();
        chk("drain done busy", int'(busy), 0);
        chk("drain done valid", int'(bus.out_valid), 0);
        tick();
        chk("drain en low idle", int'(bus.req_ready), 0);

        // Reset in the middle of a ch2 burst
        reset_dut();
        en = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        acc = 0;
        while (bus.req_ready != 4'b0100 && acc < 30) begin
            tick();
            acc++;
        end
        chk("rst reached ch2", int'(bus.req_ready), 4);
        tick();
        rst = 1'b1;
        tick();
        check_reset("rst mid");
        rst = 1'b0;
        #1;
        chk("rst idle", int'(bus.req_ready), 0);
        tick();
        chk("rst ch0 first", int'(bus.req_ready), 1);

        // Randomized traffic against an in-order scoreboard
        reset_dut();
        for (int i = 0; i < NUM_CH; i++)
            for (int n = 0; n < 60; n++) src[i].push_back(4'($urandom));
        prev_hold = 1'b0;
        prev_pay = '0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            drain = cyc >= 3000;
            v = '0;
            d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (src[i].size() > 0) begin
                    d[4*i +: 4] = src[i][0];
                    v[i] = $urandom_range(0, 3) != 0;
                end
            end
            bus.req_valid = v;
            bus.req_data = d;
            bus.out_ready = drain || $urandom_range(0, 3) != 0;
            en = drain || $urandom_range(0, 15) != 0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("rnd spurious output", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("rnd out_ch", int'(bus.out_ch), e.ch);
                    chk("rnd out_data", int'(bus.out_data), e.code);
                    chk("rnd out_oor", int'(bus.out_oor), int'(e.oor));
                end
            end
            chk("rnd onehot", $countones(bus.req_ready) <= 1 ? 1 : 0, 1);
            if (bus.out_valid && !bus.out_ready) chk("rnd bp ready", int'(bus.req_ready), 0);
            if (prev_hold) chk("rnd stable", int'({bus.out_valid, bus.out_data, bus.out_ch, bus.out_oor}), int'(prev_pay));
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_pay = {bus.out_valid, bus.out_data, bus.out_ch, bus.out_oor};
            acc = -1;
            for (int i = 0; i < NUM_CH; i++)
                if (v[i] && bus.req_ready[i]) acc = i;
            if (acc >= 0) begin
                e.ch = acc;
                e.code = model_code(int'($signed(src[acc][0])));
                e.oor = model_oor(int'($signed(src[acc][0])));
                expq.push_back(e);
            end
            tick();
            if (acc >= 0) void'(src[acc].pop_front());
            left = 0;
            for (int i = 0; i < NUM_CH; i++) left += src[i].size();
            if (drain && left == 0 && expq.size() == 0 && !bus.out_valid) break;
        end
        left = 0;
        for (int i = 0; i < NUM_CH; i++) left += src[i].size();
        chk("rnd sources consumed", left, 0);
        chk("rnd outputs delivered", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
